// File: rtl/pe_scalar_seq.sv
// Scalar control sequencer feeding the CGRA scalar PE: program memory, register file, lui/addi/beq/halt.
// Optional busy-cycle counter on perf_cycles is enabled by defining PE_SEQ_PERF_CNT_EN.
module pe_scalar_seq #(
  parameter int DWIDTH_INT = 32,
  parameter int NREG       = 8,
  parameter int DEPTH      = 32,
  localparam int RW        = $clog2(NREG),
  localparam int PW        = $clog2(DEPTH),
  localparam int IW        = 3 + 3*RW + DWIDTH_INT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_we,
  input  logic [PW-1:0]         prog_addr,
  input  logic [IW-1:0]         prog_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            pe_op,
  output logic [DWIDTH_INT-1:0] pe_inp1,
  output logic [DWIDTH_INT-1:0] pe_inp2,
  output logic [DWIDTH_INT-1:0] pe_imm,
  input  logic [DWIDTH_INT-1:0] pe_out1,
  input  logic                  pe_flag_eq,
  input  logic [RW-1:0]         rf_raddr,
  output logic [DWIDTH_INT-1:0] rf_rdata,
  output logic [31:0]           perf_cycles,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] OP_LUI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_BEQ  = 3'b010;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_mem [DEPTH];
  logic [DWIDTH_INT-1:0] r_rf [NREG];
  logic [IW-1:0]         r_instr;
  logic [PW-1:0]         r_pc;
  logic [2:0]            r_pe_op;
  logic [DWIDTH_INT-1:0] r_pe_inp1;
  logic [DWIDTH_INT-1:0] r_pe_inp2;
  logic [DWIDTH_INT-1:0] r_pe_imm;

  logic                  w_start_ok;
  logic [2:0]            w_op;
  logic [RW-1:0]         w_rd;
  logic [RW-1:0]         w_rs1;
  logic [RW-1:0]         w_rs2;
  logic [DWIDTH_INT-1:0] w_imm;

  assign w_op  = r_instr[IW-1 -: 3];
  assign w_rd  = r_instr[DWIDTH_INT + 2*RW +: RW];
  assign w_rs1 = r_instr[DWIDTH_INT + RW +: RW];
  assign w_rs2 = r_instr[DWIDTH_INT +: RW];
  assign w_imm = r_instr[DWIDTH_INT-1:0];

  assign busy       = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WB);
  assign done       = (r_state == S_DONE);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign pe_op      = r_pe_op;
  assign pe_inp1    = r_pe_inp1;
  assign pe_inp2    = r_pe_inp2;
  assign pe_imm     = r_pe_imm;
  assign rf_rdata   = r_rf[rf_raddr];
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_FETCH;
      S_FETCH:        w_next = S_ISSUE;
      S_ISSUE:        w_next = (w_op == OP_HALT) ? S_DONE : S_WB;
      S_WB:           w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end

  // Program memory is not reset; writes are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) r_mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= '0;
      r_instr   <= '0;
      r_pe_op   <= '0;
      r_pe_inp1 <= '0;
      r_pe_inp2 <= '0;
      r_pe_imm  <= '0;
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_start_ok) r_pc <= '0;
        S_FETCH: r_instr <= r_mem[r_pc];
        S_ISSUE: begin
          if (w_op != OP_HALT) begin
            r_pe_op   <= w_op;
            r_pe_inp1 <= r_rf[w_rs1];
            r_pe_inp2 <= r_rf[w_rs2];
            r_pe_imm  <= w_imm;
          end
        end
        S_WB: begin
          // lui takes the immediate directly: the PE yields 0 for that opcode.
          case (w_op)
            OP_LUI:  begin r_rf[w_rd] <= w_imm;   r_pc <= r_pc + PW'(1); end
            OP_ADDI: begin r_rf[w_rd] <= pe_out1; r_pc <= r_pc + PW'(1); end
            OP_BEQ:  r_pc <= pe_flag_eq ? (r_pc + w_imm[PW-1:0]) : (r_pc + PW'(1));
            default: r_pc <= r_pc + PW'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef PE_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk) begin
    if (rst || w_start_ok)          r_perf <= '0;
    else if (busy && r_perf != '1)  r_perf <= r_perf + 32'd1;
  end
  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_scalar_seq.sv
// Directed bench for pe_scalar_seq with a behavioural scalar PE and a register scoreboard.
module tb_pe_scalar_seq;
  localparam int DW = 32;
  localparam int RW = 3;
  localparam int PW = 5;
  localparam int IW = 3 + 3*RW + DW;
  localparam logic [2:0] LUI = 3'b000, ADDI = 3'b001, BEQ = 3'b010, NOP5 = 3'b101, HALT = 3'b111;
`ifdef PE_SEQ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [PW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_data = '0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [2:0]    pe_op;
  logic [DW-1:0] pe_inp1, pe_inp2, pe_imm, pe_out1;
  logic          pe_flag_eq;
  logic [RW-1:0] rf_raddr = '0;
  logic [DW-1:0] rf_rdata;
  logic [31:0]   perf_cycles;
  logic [2:0]    dbg_state;

  pe_scalar_seq dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .busy(busy), .done(done), .pe_op(pe_op), .pe_inp1(pe_inp1),
    .pe_inp2(pe_inp2), .pe_imm(pe_imm), .pe_out1(pe_out1), .pe_flag_eq(pe_flag_eq),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .perf_cycles(perf_cycles), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scalar PE model: addi adds the immediate, everything else returns 0; eq flag compares operands.
  always_comb begin
    pe_out1    = (pe_op == ADDI) ? (pe_inp1 + pe_imm) : '0;
    pe_flag_eq = (pe_inp1 == pe_inp2);
  end

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] idx_q[$];

  function automatic logic [IW-1:0] enc(input logic [2:0] op, input logic [RW-1:0] rd,
                                        input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                                        input logic [DW-1:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] perf_exp(input int n);
    return PERF_ON ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [IW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr[PW-1:0]; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic expect_reg(input int idx, input logic [DW-1:0] val);
    idx_q.push_back(idx[RW-1:0]);
    exp_q.push_back(val);
  endtask

  task automatic drain_sb(input string tag);
    logic [RW-1:0] idx;
    logic [DW-1:0] e;
    while (exp_q.size() > 0) begin
      idx = idx_q.pop_front();
      e   = exp_q.pop_front();
      rf_raddr = idx;
      #1;
      check($sformatf("%s_r%0d", tag, idx), rf_rdata, e);
    end
  endtask

  // Pulses start, then counts busy cycles until done (bounded). With inject set, a program
  // write and a second start are driven while the sequencer is busy.
  task automatic run_prog(input string tag, input bit inject, output int cyc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      if (inject && k == 2) begin
        prog_we = 1'b1; prog_addr = 5'd2; prog_data = enc(LUI, 3'd6, 3'd0, 3'd0, 32'd99); start = 1'b1;
      end else if (inject && k == 3) begin
        prog_we = 1'b0; start = 1'b0;
      end
      if (done) break;
      if (busy) cyc++;
      @(negedge clk);
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    bit            found;
    logic [DW-1:0] ra, rb;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_perf", perf_cycles, 32'd0);
    check("rst_pe_op", {29'd0, pe_op}, 32'd0);
    check("rst_pe_imm", pe_imm, 32'd0);
    rst = 1'b0;

    // Basic lui/addi/halt
    load(0, enc(LUI,  3'd1, 3'd0, 3'd0, 32'd7));
    load(1, enc(ADDI, 3'd3, 3'd1, 3'd0, 32'd5));
    load(2, enc(HALT, 3'd0, 3'd0, 3'd0, 32'd0));
    run_prog("basic", 1'b0, cyc);
    check("basic_busy_cycles", 32'(cyc), 32'd8);
    check("basic_perf", perf_cycles, perf_exp(8));
    check("basic_pe_op_held", {29'd0, pe_op}, 32'd1);
    check("basic_pe_imm_held", pe_imm, 32'd5);
    expect_reg(1, 32'd7);
    expect_reg(3, 32'd12);
    drain_sb("basic");

    // Writes and start while busy are ignored
    run_prog("busy_ign", 1'b1, cyc);
    check("busy_ign_cycles", 32'(cyc), 32'd8);
    expect_reg(3, 32'd12);
    expect_reg(6, 32'd0);
    drain_sb("busy_ign");
    run_prog("busy_ign_rerun", 1'b0, cyc);
    check("busy_ign_rerun_cycles", 32'(cyc), 32'd8);
    expect_reg(6, 32'd0);
    drain_sb("busy_ign_rerun");

    // Counting loop
    load(0, enc(LUI,  3'd1, 3'd0, 3'd0, 32'd0));
    load(1, enc(LUI,  3'd2, 3'd0, 3'd0, 32'd5));
    load(2, enc(ADDI, 3'd1, 3'd1, 3'd0, 32'd1));
    load(3, enc(BEQ,  3'd0, 3'd1, 3'd2, 32'd2));
    load(4, enc(BEQ,  3'd0, 3'd0, 3'd0, 32'hFFFF_FFFE));
    load(5, enc(HALT, 3'd0, 3'd0, 3'd0, 32'd0));
    run_prog("loop", 1'b0, cyc);
    check("loop_busy_cycles", 32'(cyc), 32'd50);
    check("loop_perf", perf_cycles, perf_exp(50));
    expect_reg(1, 32'd5);
    expect_reg(2, 32'd5);
    drain_sb("loop");

    // Reset during WB, then restart
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k >= 12 && dbg_state == 3'd3) begin found = 1'b1; break; end
      @(negedge clk);
    end
    check("midrst_wb_reached", {31'd0, found}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_pe_op", {29'd0, pe_op}, 32'd0);
    check("midrst_pe_inp1", pe_inp1, 32'd0);
    check("midrst_pe_inp2", pe_inp2, 32'd0);
    check("midrst_pe_imm", pe_imm, 32'd0);
    check("midrst_perf", perf_cycles, 32'd0);
    for (int i = 0; i < 8; i++) expect_reg(i, 32'd0);
    drain_sb("midrst");
    rst = 1'b0;
    run_prog("restart", 1'b0, cyc);
    check("restart_busy_cycles", 32'(cyc), 32'd50);
    expect_reg(1, 32'd5);
    drain_sb("restart");

    // Branch wrap-around across the end of program memory
    pulse_rst();
    load(0,  enc(BEQ,  3'd0, 3'd0, 3'd0, 32'd31));
    load(1,  enc(LUI,  3'd4, 3'd0, 3'd0, 32'hBAD));
    load(2,  enc(HALT, 3'd0, 3'd0, 3'd0, 32'd0));
    load(31, enc(BEQ,  3'd0, 3'd0, 3'd0, 32'd3));
    run_prog("wrap", 1'b0, cyc);
    check("wrap_busy_cycles", 32'(cyc), 32'd8);
    check("wrap_pe_imm", pe_imm, 32'd3);
    expect_reg(4, 32'd0);
    drain_sb("wrap");

    // addi overflow and an unused opcode behaving as a NOP
    load(0, enc(LUI,  3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF));
    load(1, enc(ADDI, 3'd2, 3'd1, 3'd0, 32'd1));
    load(2, enc(NOP5, 3'd1, 3'd2, 3'd0, 32'h1234));
    load(3, enc(HALT, 3'd0, 3'd0, 3'd0, 32'd0));
    run_prog("ovf", 1'b0, cyc);
    check("ovf_busy_cycles", 32'(cyc), 32'd11);
    check("ovf_pe_op", {29'd0, pe_op}, 32'd5);
    expect_reg(1, 32'hFFFF_FFFF);
    expect_reg(2, 32'd0);
    drain_sb("ovf");

    // Random operands through lui/addi
    for (int t = 0; t < 3; t++) begin
      ra = {16'(t), 16'($urandom_range(0, 65535))};
      rb = 32'($urandom_range(0, 100000));
      load(0, enc(LUI,  3'd5, 3'd0, 3'd0, ra));
      load(1, enc(ADDI, 3'd6, 3'd5, 3'd0, rb));
      load(2, enc(HALT, 3'd0, 3'd0, 3'd0, 32'd0));
      run_prog("rand", 1'b0, cyc);
      expect_reg(5, ra);
      expect_reg(6, ra + rb);
      drain_sb("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_scalar_seq.md
Name: pe_scalar_seq

Overview:
- Scalar control sequencer sitting directly upstream of the CGRA scalar PE.
- Holds a small program memory and a scalar register file.
- Fetches lui/addi/beq/halt instructions, drives the scalar PE's operand and opcode inputs, and consumes its result and equality flag to write back registers and resolve branches.
- Host loads the program, pulses start, and waits for done; loop counters are then readable from the register file.

Parameters:
- DWIDTH_INT, 32: scalar datapath width; equals PE operand width.
- NREG, 8: scalar registers (power of 2); RW = log2(NREG).
- DEPTH, 32: program memory entries (power of 2); PW = log2(DEPTH).
- IW, 3+3*RW+DWIDTH_INT: instruction width. Fields, MSB first: op[2:0], rd, rs1, rs2, imm[DWIDTH_INT-1:0].

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- prog_we  in  1  program write strobe
- prog_addr  in  PW  program write address
- prog_data  in  IW  program write data
- start  in  1  begin execution at pc 0
- busy  out  1  sequencer executing
- done  out  1  high from halt until next start or rst
- pe_op  out  3  to PE op_scalar
- pe_inp1  out  DWIDTH_INT  to PE inp1 (reg[rs1])
- pe_inp2  out  DWIDTH_INT  to PE inp2 (reg[rs2])
- pe_imm  out  DWIDTH_INT  to PE R_immediate
- pe_out1  in  DWIDTH_INT  from PE out1
- pe_flag_eq  in  1  from PE flag_eq
- rf_raddr  in  RW  host register read address
- rf_rdata  out  DWIDTH_INT  combinational reg[rf_raddr]
- perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Opcodes: 000 lui, 001 addi, 010 beq, 111 halt; 011–110 are NOPs (pc+1, no write).
- Reset: state IDLE; pc, all registers, busy, done, pe_* outputs and perf_cycles = 0. Program memory is not cleared.
- Reset has priority in any state; a mid-run reset returns to IDLE with no further register writes.
- Program memory: synchronous write.
  - prog_we is honoured only when busy=0; it is ignored while busy.
  - Read is synchronous, 1-cycle latency.
- FSM states: IDLE, FETCH, ISSUE, WB, DONE.
- IDLE/DONE + start=1 → FETCH:
  - pc=0, done cleared on that edge.
  - start is ignored while busy.
- FETCH (busy=1): present pc to memory → ISSUE.
- ISSUE:
  - Register pe_op=op, pe_inp1=reg[rs1], pe_inp2=reg[rs2], pe_imm=imm.
  - If op=halt, go to DONE without driving the PE. pe_* hold their previous values; busy=0, done=1.
  - Otherwise go to WB.
- WB: sample pe_out1/pe_flag_eq, which are combinational from the registered pe_* values.
  - lui: reg[rd] = imm, taken from the instruction, not from pe_out1, because the PE returns 0 for lui. pc+1.
  - addi: reg[rd] = pe_out1, wrapping mod 2^DWIDTH_INT. pc+1.
  - beq: no register write. If pe_flag_eq, pc = pc + imm[PW-1:0]; otherwise pc+1.
  - All pc arithmetic is mod DEPTH, so wrap-around is legal.
  - Then → FETCH.
- Timing: 3 cycles per non-halt instruction; halt costs 2 (FETCH, ISSUE).
- rd = rs1 read-after-write is safe because writeback completes before the next ISSUE.
- No register is hardwired; r0 is 0 only by reset.
- An infinite loop is legal; only rst or halt exits it.

Optional Feature:
- Macro PE_SEQ_PERF_CNT_EN.
- Defined: perf_cycles increments each cycle busy=1 (saturates at 2^32-1), clears on rst and on an accepted start.
- Undefined: no counter logic; perf_cycles is tied to 0.

Test Plan:
- Load 0: lui r1,7; 1: addi r3,r1,5; 2: halt; pulse start.
  - Expect done=1, r1=7, r3=12, busy high for 8 cycles.
- Loop program:
  - 0: lui r1,0; 1: lui r2,5; 2: addi r1,r1,1; 3: beq r1,r2,+2; 4: beq r0,r0,-2 (imm=all-ones−1); 5: halt.
  - Expect r1=5, done=1, perf_cycles=50 with macro defined, 0 without.
- Branch wrap, DEPTH=32:
  - pc 31: beq r0,r0,+3 → next fetch at pc 2; place halt at 2 and a jump to 31 at pc 0.
  - Expect clean halt with no out-of-range access.
- Assert rst during WB of the loop program.
  - Next cycle: busy=0, done=0, all registers 0, pe_* 0.
  - Then a restart runs to r1=5.
- While busy: drive prog_we to overwrite the halt, and pulse start.
  - Both are ignored; the program completes unchanged, and pc is not reset by the mid-run start.
- Addi overflow: r1=0xFFFFFFFF (via lui), addi r2,r1,1 → r2=0. Opcode 101 executes as a NOP; registers unchanged, pc+1.
